mips_cache_wb: RTL and testbench

MIPS_CACHE_WB -- requirements
Module: mips_cache_wb

---
 rtl/mips_cache_wb.sv | 193 +++++++++++++++++++
 tb/tb_mips_cache_wb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cache_wb.sv
// mips_cache_wb: direct-mapped, write-back, write-allocate cache.
// The CPU side moves single words and completes with a one-cycle cpu_ready
// pulse. The memory side moves whole lines with a valid/ready handshake.
module mips_cache_wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int CACHE_DEPTH    = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ADDR_WIDTH-1:0]                cpu_addr,
    input  logic                                 cpu_valid,
    input  logic                                 cpu_write,
    input  logic [DATA_WIDTH-1:0]                cpu_wdata,
    output logic                                 cpu_ready,
    output logic [DATA_WIDTH-1:0]                cpu_rdata,
    output logic                                 cache_hit,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic                                 mem_valid,
    output logic                                 mem_write,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                                 mem_ready,
    output logic [COUNT_WIDTH-1:0]               hit_count,
    output logic [COUNT_WIDTH-1:0]               miss_count
);
    localparam int LINE_W   = DATA_WIDTH * WORDS_PER_LINE;
    localparam int BYTE_OFF = $clog2(DATA_WIDTH / 8);
    localparam int OFF      = BYTE_OFF + $clog2(WORDS_PER_LINE);
    localparam int IDX      = $clog2(CACHE_DEPTH);
    localparam int TAG      = ADDR_WIDTH - IDX - OFF;
    localparam int WSEL_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t                 state_q, state_d;

    // Registered request, captured when the request is accepted in IDLE
    logic [TAG-1:0]         req_tag_q;
    logic [IDX-1:0]         req_idx_q;
    logic [WSEL_W-1:0]      req_word_q;
    logic                   req_write_q;
    logic [DATA_WIDTH-1:0]  req_wdata_q;
    logic                   first_q;

    // Line storage: only valid/dirty carry reset, tags and data do not
    logic [CACHE_DEPTH-1:0] valid_q, dirty_q;
    logic [TAG-1:0]         tag_q  [CACHE_DEPTH];
    logic [LINE_W-1:0]      data_q [CACHE_DEPTH];

    logic                   cpu_ready_q, cache_hit_q;
    logic [DATA_WIDTH-1:0]  cpu_rdata_q;
    logic [COUNT_WIDTH-1:0] hit_count_q, miss_count_q;

    logic [WSEL_W-1:0]      cpu_word;
    logic [TAG-1:0]         line_tag;
    logic [LINE_W-1:0]      line_data;
    logic                   line_valid, line_dirty, hit;
    logic                   accept, fill_done, wr_hit;
    logic                   unused_addr;

    generate
        if (WORDS_PER_LINE > 1) begin : g_wsel
            assign cpu_word = cpu_addr[OFF-1:BYTE_OFF];
        end else begin : g_wsel_one
            assign cpu_word = 1'b0;
        end
    endgenerate

    // Byte-offset bits never select anything; fold them away explicitly.
    assign unused_addr = ^cpu_addr;

    assign line_tag   = tag_q[req_idx_q];
    assign line_data  = data_q[req_idx_q];
    assign line_valid = valid_q[req_idx_q];
    assign line_dirty = dirty_q[req_idx_q];
    assign hit        = line_valid && (line_tag == req_tag_q);

    assign accept    = (state_q == IDLE) && cpu_valid;
    assign fill_done = (state_q == ALLOCATE) && mem_ready;
    assign wr_hit    = (state_q == COMPARE) && hit && req_write_q;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and memory-port outputs, decoded from the current state only
    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (cpu_valid) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit)                          state_d = IDLE;
                else if (line_valid && line_dirty) state_d = WRITE_BACK;
                else                              state_d = ALLOCATE;
            end
            WRITE_BACK: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = ADDR_WIDTH'({line_tag, req_idx_q}) << OFF;
                mem_wdata = line_data;
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_WIDTH'({req_tag_q, req_idx_q}) << OFF;
                if (mem_ready) state_d = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture; the CPU holds its fields until completion
    always_ff @(posedge clock) begin
        if (accept) begin
            req_tag_q   <= cpu_addr[ADDR_WIDTH-1 -: TAG];
            req_idx_q   <= cpu_addr[OFF +: IDX];
            req_word_q  <= cpu_word;
            req_write_q <= cpu_write;
            req_wdata_q <= cpu_wdata;
        end
    end

    // Line data and tag updates: whole-line fill or single-word write hit
    always_ff @(posedge clock) begin
        if (fill_done) begin
            data_q[req_idx_q] <= mem_rdata;
            tag_q[req_idx_q]  <= req_tag_q;
        end else if (wr_hit) begin
            data_q[req_idx_q][req_word_q*DATA_WIDTH +: DATA_WIDTH] <= req_wdata_q;
        end
    end

    // Valid and dirty bits; a fill leaves the line clean, a write hit dirties it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[req_idx_q] <= 1'b1;
            dirty_q[req_idx_q] <= 1'b0;
        end else if (wr_hit) begin
            dirty_q[req_idx_q] <= 1'b1;
        end
    end

    // CPU completion, statistics (first COMPARE only) and first-compare flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_ready_q  <= 1'b0;
            cache_hit_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            first_q      <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            cache_hit_q <= 1'b0;
            if (state_q == COMPARE) begin
                if (hit) begin
                    cpu_ready_q <= 1'b1;
                    cache_hit_q <= first_q;
                    cpu_rdata_q <= line_data[req_word_q*DATA_WIDTH +: DATA_WIDTH];
                end
                if (first_q) begin
                    if (hit && (hit_count_q != '1))
                        hit_count_q <= hit_count_q + COUNT_WIDTH'(1);
                    if (!hit && (miss_count_q != '1))
                        miss_count_q <= miss_count_q + COUNT_WIDTH'(1);
                end
            end
            if (accept)                    first_q <= 1'b1;
            else if (state_q == COMPARE)   first_q <= 1'b0;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cache_hit  = cache_hit_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_mips_cache_wb.sv
// Testbench for mips_cache_wb: randomized and directed requests against a
// flat-memory reference model, with queued expectations popped by separate
// CPU-side and memory-side monitors. A second instance with 4-bit counters
// shares all stimulus to observe counter saturation.
module tb_mips_cache_wb;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_valid, cpu_write;
    logic         cpu_ready, cache_hit;
    logic [31:0]  cpu_rdata;
    logic [31:0]  mem_addr;
    logic         mem_valid, mem_write;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic [31:0]  hit_count, miss_count;

    logic         d4_cpu_ready, d4_cache_hit, d4_mem_valid, d4_mem_write;
    logic [31:0]  d4_cpu_rdata, d4_mem_addr;
    logic [127:0] d4_mem_wdata;
    logic [3:0]   d4_hit_count, d4_miss_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mips_cache_wb dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cache_hit(cache_hit), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    mips_cache_wb #(.COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_ready(d4_cpu_ready), .cpu_rdata(d4_cpu_rdata),
        .cache_hit(d4_cache_hit), .mem_addr(d4_mem_addr), .mem_valid(d4_mem_valid),
        .mem_write(d4_mem_write), .mem_wdata(d4_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_count(d4_hit_count), .miss_count(d4_miss_count)
    );

    typedef struct packed { logic [31:0] rdata; logic hit; logic rd; } cpu_exp_t;
    typedef struct packed { logic wr; logic [31:0] addr; logic [127:0] data; } mem_exp_t;

    cpu_exp_t cpuq[$];
    mem_exp_t memq[$];

    // Reference model: which line sits in each slot, plus two flat word memories:
    // ref_mem is what the CPU must observe, mmem is what main memory should hold.
    bit          m_valid [8];
    bit          m_dirty [8];
    int unsigned m_tag   [8];
    int unsigned hit_m, miss_m;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] mmem    [int unsigned];
    logic [31:0] bmem    [int unsigned];

    bit           hold_alloc;
    logic [31:0]  last_wb_addr;
    logic [127:0] last_wb_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned w);
        return 32'(w * 32'h9E3779B1 + 32'h0BADF00D);
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] bmem_get(input int unsigned w);
        if (bmem.exists(w)) return bmem[w];
        return init_word(w);
    endfunction

    function automatic logic [3:0] sat4(input int unsigned x);
        return (x > 15) ? 4'd15 : 4'(x);
    endfunction

    task automatic set_mem(input int unsigned w, input logic [31:0] v);
        ref_mem[w] = v;
        mmem[w]    = v;
        bmem[w]    = v;
    endtask

    task automatic model_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                             output bit hit);
        int unsigned idx, tag, oldbase;
        cpu_exp_t    ce;
        mem_exp_t    me;
        idx = (a >> 4) & 7;
        tag = a >> 7;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) begin
            hit_m++;
        end else begin
            miss_m++;
            if (m_valid[idx] && m_dirty[idx]) begin
                oldbase = (m_tag[idx] << 5) | (idx << 2);
                me.wr   = 1'b1;
                me.addr = oldbase << 2;
                me.data = '0;
                for (int k = 0; k < 4; k++) begin
                    me.data[k*32 +: 32] = ref_get(oldbase + k);
                    mmem[oldbase + k]   = ref_get(oldbase + k);
                end
                memq.push_back(me);
            end
            me.wr   = 1'b0;
            me.addr = a & ~32'hF;
            me.data = '0;
            memq.push_back(me);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        if (w) begin
            ref_mem[a >> 2] = d;
            m_dirty[idx]    = 1'b1;
        end
        ce.rd    = !w;
        ce.hit   = hit;
        ce.rdata = w ? 32'h0 : ref_get(a >> 2);
        cpuq.push_back(ce);
    endtask

    // Reset empties the cache; anything only held in dirty lines is lost.
    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        hit_m  = 0;
        miss_m = 0;
        ref_mem.delete();
        foreach (mmem[k]) ref_mem[k] = mmem[k];
        cpuq.delete();
        memq.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_cache_hit", cache_hit, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        chk("rst_d4_mem_valid", d4_mem_valid, 1'b0);
        model_reset();
        hold_alloc = 1'b0;
        cpu_valid  = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic issue_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                             output bit hit);
        model_req(a, w, d, hit);
        @(negedge clock);
        cpu_addr  = a;
        cpu_write = w;
        cpu_wdata = d;
        cpu_valid = 1'b1;
        @(posedge clock);
    endtask

    task automatic wait_done(input bit hit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
            if (cpu_ready) begin
                done      = 1'b1;
                cpu_valid = 1'b0;
            end else begin
                cpu_valid = 1'($urandom_range(0, 1));
            end
        end
        cpu_valid = 1'b0;
        chk("cpu_ready_timeout", done, 1'b1);
        if (hit) chk("hit_latency", n, 2);
        chk("hit_count", hit_count, hit_m);
        chk("miss_count", miss_count, miss_m);
        chk("d4_hit_count", d4_hit_count, sat4(hit_m));
        chk("d4_miss_count", d4_miss_count, sat4(miss_m));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_write = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit h;
        issue_req(a, w, d, h);
        wait_done(h);
    endtask

    // CPU-side monitor: every completion pops one expected response
    initial begin : cpu_monitor
        cpu_exp_t e;
        forever begin
            @(negedge clock);
            if (reset && cpu_ready) begin
                chk("cpu_resp_expected", cpuq.size() != 0, 1'b1);
                if (cpuq.size() != 0) begin
                    e = cpuq.pop_front();
                    chk("cache_hit", cache_hit, e.hit);
                    chk("d4_cpu_ready", d4_cpu_ready, 1'b1);
                    chk("d4_cache_hit", d4_cache_hit, e.hit);
                    if (e.rd) begin
                        chk("cpu_rdata", cpu_rdata, e.rdata);
                        chk("d4_cpu_rdata", d4_cpu_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // Memory responder and memory-side monitor; also injects stray mem_ready
    // pulses while no memory request is outstanding.
    initial begin : mem_responder
        int          wait_n;
        int unsigned base;
        mem_exp_t    e;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_n    = -1;
        forever begin
            @(negedge clock);
            if (mem_ready) begin
                mem_ready = 1'b0;
                continue;
            end
            if (!mem_valid) begin
                wait_n = -1;
                if (reset && $urandom_range(0, 7) == 0) mem_ready = 1'b1;
                continue;
            end
            if (hold_alloc && !mem_write) begin
                wait_n = -1;
                continue;
            end
            if (wait_n < 0) wait_n = int'($urandom_range(0, 3));
            if (wait_n > 0) begin
                wait_n--;
                continue;
            end
            wait_n = -1;
            chk("mem_req_expected", memq.size() != 0, 1'b1);
            if (memq.size() != 0) begin
                e = memq.pop_front();
                chk("mem_write", mem_write, e.wr);
                chk("mem_addr", mem_addr, e.addr);
                chk("d4_mem_valid", d4_mem_valid, 1'b1);
                chk("d4_mem_write", d4_mem_write, e.wr);
                chk("d4_mem_addr", d4_mem_addr, e.addr);
                if (e.wr) begin
                    chk("mem_wdata", mem_wdata, e.data);
                    chk("d4_mem_wdata", d4_mem_wdata, e.data);
                end
            end
            base = (mem_addr & ~32'hF) >> 2;
            if (mem_write) begin
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
                for (int k = 0; k < 4; k++) bmem[base + k] = mem_wdata[k*32 +: 32];
            end else begin
                for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] = bmem_get(base + k);
            end
            mem_ready = 1'b1;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          h;
        int          n, bad;
        logic [31:0] a;
        reset      = 1'b1;
        cpu_valid  = 1'b0;
        cpu_write  = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        hold_alloc = 1'b0;
        last_wb_addr = '0;
        last_wb_data = '0;
        model_reset();
        pulse_reset();

        // Fill line 0x10 with known words, then read-miss / read-hit / write-hit
        set_mem(32'h10 >> 2, 32'h11111111);
        set_mem(32'h14 >> 2, 32'h22222222);
        set_mem(32'h18 >> 2, 32'h33333333);
        set_mem(32'h1C >> 2, 32'h44444444);
        do_req(32'h14, 1'b0, 32'h0);
        chk("first_miss_count", miss_count, 32'd1);
        do_req(32'h18, 1'b0, 32'h0);
        chk("first_hit_count", hit_count, 32'd1);
        do_req(32'h1C, 1'b1, 32'hDEADBEEF);

        // Conflict miss on a dirty line, memory stalled in ALLOCATE, then reset
        hold_alloc = 1'b1;
        issue_req(32'h90, 1'b0, 32'h0, h);
        n = 0;
        do begin
            @(negedge clock);
            cpu_valid = 1'b0;
            n++;
        end while (!(mem_valid && !mem_write) && n < 100);
        chk("alloc_reached", mem_valid && !mem_write, 1'b1);
        chk("wb_addr", last_wb_addr, 32'h10);
        chk("wb_data", last_wb_data, 128'hDEADBEEF_33333333_22222222_11111111);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!mem_valid || mem_write || mem_addr != 32'h90 || cpu_ready) bad++;
        end
        chk("alloc_stall_stable", bad, 0);
        pulse_reset();
        do_req(32'h14, 1'b0, 32'h0);
        chk("post_reset_miss_count", miss_count, 32'd1);

        // Dirty data held only in the cache is dropped by reset
        do_req(32'h204, 1'b1, 32'hCAFEF00D);
        pulse_reset();
        do_req(32'h204, 1'b0, 32'h0);

        // Randomized traffic over 4 tags x 8 lines x 4 words
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            do_req(a, 1'($urandom_range(0, 9) < 4), $urandom);
        end

        // Saturation of the 4-bit counters under repeated read hits
        pulse_reset();
        do_req(32'h18, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) do_req(32'h18, 1'b0, 32'h0);
        chk("sat_d4_hit_count", d4_hit_count, 4'd15);
        chk("sat_hit_count_32", hit_count, 32'd20);
        do_req(32'h18, 1'b0, 32'h0);
        chk("sat_d4_hit_hold", d4_hit_count, 4'd15);

        repeat (3) @(negedge clock);
        chk("cpu_queue_drained", cpuq.size(), 0);
        chk("mem_queue_drained", memq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
